csr_regfile: RTL
================

Name: csr_regfile

Overview:
AXI4-lite slave register file for the bster control/status path.
- Exposes NB_CTRL read/write control registers, driven out on csr_o.
- Exposes NB_STAT read-only status registers, sampled from csr_i.
- Generalises the fixed-width CSR slave: real write/read handshakes, byte strobes, error responses, a per-register write-strobe pulse and a parametrised register count.
- Sits between the host AXI4-lite master and the bster core.

Parameters:
- CSR_ADDR_WIDTH, 8, AXI address width in bits.
- CSR_DATA_WIDTH, 32, AXI data and register width in bits; must be 32 or 64.
- NB_CTRL, 4, number of RW control registers (1..16).
- NB_STAT, 4, number of RO status registers (0..16).
- CTRL_INIT, 0, reset value of all control registers (NB_CTRL*CSR_DATA_WIDTH bits; register k = slice k).

Ports:
- aclk  in  1  clock
- aresetn  in  1  asynchronous active-low reset
- awvalid/awready  in/out  1  write address handshake
- awaddr  in  CSR_ADDR_WIDTH  byte address
- awprot  in  3  ignored
- wvalid/wready  in/out  1  write data handshake
- wdata  in  CSR_DATA_WIDTH  write data
- wstrb  in  CSR_DATA_WIDTH/8  byte enables
- bvalid/bready  out/in  1  write response handshake
- bresp  out  2  write response
- arvalid/arready  in/out  1  read address handshake
- araddr  in  CSR_ADDR_WIDTH  byte address
- arprot  in  3  ignored
- rvalid/rready  out/in  1  read data handshake
- rdata  out  CSR_DATA_WIDTH  read data
- rresp  out  2  read response
- csr_i  in  NB_STAT*CSR_DATA_WIDTH  status inputs; register k = slice k
- csr_o  out  NB_CTRL*CSR_DATA_WIDTH  control register contents
- csr_wr  out  NB_CTRL  one-cycle pulse per control register on an accepted write

Behaviour:
- Single clock aclk. aresetn is asynchronous and active-low.
- Reset values:
  - awready, wready, arready = 0 while aresetn=0.
  - bvalid, rvalid = 0; bresp, rresp = 0; rdata = 0.
  - csr_o = CTRL_INIT; csr_wr = 0; capture flags cleared.
- Address decode:
  - idx = addr >> log2(CSR_DATA_WIDTH/8); low address bits ignored.
  - idx < NB_CTRL: control register idx.
  - NB_CTRL <= idx < NB_CTRL+NB_STAT: status register idx-NB_CTRL.
  - Otherwise unmapped.
- Write channel:
  - AW and W are captured independently into one-entry holding registers (aw_held, w_held).
  - awready = aresetn & !aw_held & !bvalid; wready = aresetn & !w_held & !bvalid.
  - Commit occurs at the first rising edge where an address is available (held or handshaking) and data is available (held or handshaking). At that edge:
    - Apply the write, set bvalid=1 and clear both held flags.
  - Both handshakes in cycle N -> csr_o updated, csr_wr[idx]=1 and bvalid=1 in cycle N+1.
  - AW in cycle N, W in cycle M>N -> commit effective in cycle M+1.
- Write effect:
  - Control target: byte b of register idx is replaced by wdata byte b only when wstrb[b]=1; bresp=OKAY (00).
  - wstrb=0 still returns OKAY and pulses csr_wr.
  - Status target: no state change, no pulse, bresp=SLVERR (10).
  - Unmapped target: no state change, no pulse, bresp=DECERR (11).
- Write response:
  - bvalid and bresp hold stable until bready=1.
  - bvalid clears on the edge where bvalid&bready.
  - At most one write outstanding; no new AW/W accepted while bvalid=1.
- csr_wr:
  - High exactly one cycle per committed control write.
  - Back-to-back writes to the same register give separate pulses.
- Read channel:
  - arready = aresetn & !rvalid.
  - ar handshake in cycle N -> rvalid=1 in cycle N+1, with rdata/rresp registered at that edge.
  - Control: rdata = csr_o value before any write committing on the same edge; rresp=OKAY.
  - Status: rdata = csr_i slice sampled at the same edge; rresp=OKAY.
  - Unmapped: rdata=0, rresp=DECERR.
  - rvalid, rdata and rresp hold until rready; one read outstanding.
- Simultaneous read and write to the same control register in one cycle: the read returns the old value and the write takes effect. Channels are fully independent.
- Reset asserted mid-transaction:
  - Pending captures and responses are dropped and csr_o returns to CTRL_INIT immediately.
  - No response is issued for the aborted transaction after release.

Test Plan:
- Reset with CTRL_INIT slice 0 = 0xA5A5_0000 -> csr_o[31:0]=0xA5A5_0000; all valid/ready outputs 0 during reset.
- Same-cycle AW+W: awaddr=0x04, wdata=0x1234_5678, wstrb=0xF -> next cycle csr_o[63:32]=0x1234_5678, csr_wr=0b0010 for 1 cycle, bvalid=1, bresp=00.
- AW at cycle 0, W at cycle 3: awaddr=0x00, wdata=0xFFFF_FFFF, wstrb=0x5 on initial 0 -> bvalid at cycle 4, csr_o[31:0]=0x00FF_00FF. Hold bready=0 for 5 cycles -> bvalid and bresp stable, awready=0.
- Write to status reg (awaddr=0x10, NB_CTRL=4) -> bresp=10, csr_o unchanged, csr_wr=0. Write to 0x40 -> bresp=11.
- Read: csr_i slice 1 = 0xDEAD_BEEF, araddr=0x14 -> rvalid next cycle, rdata=0xDEAD_BEEF, rresp=00. araddr=0x80 -> rdata=0, rresp=11. rready=0 holds rdata and keeps arready=0.
- Read 0x04 and write 0x04 with 0x0 in the same cycle (old value 0x1234_5678) -> rdata=0x1234_5678, then csr_o[63:32]=0. Assert aresetn=0 with bvalid pending -> bvalid=0 and csr_o=CTRL_INIT asynchronously.

Source files
------------

// File: rtl/csr_regfile.sv
// rtl/csr_regfile.sv - AXI4-lite control/status register file for the bster core
module csr_regfile #(
    parameter int CSR_ADDR_WIDTH = 8,
    parameter int CSR_DATA_WIDTH = 32,
    parameter int NB_CTRL        = 4,
    parameter int NB_STAT        = 4,
    parameter logic [NB_CTRL*CSR_DATA_WIDTH-1:0] CTRL_INIT = '0
) (
    input  logic                                  aclk,
    input  logic                                  aresetn,
    input  logic                                  awvalid,
    output logic                                  awready,
    input  logic [CSR_ADDR_WIDTH-1:0]             awaddr,
    input  logic [2:0]                            awprot,
    input  logic                                  wvalid,
    output logic                                  wready,
    input  logic [CSR_DATA_WIDTH-1:0]             wdata,
    input  logic [CSR_DATA_WIDTH/8-1:0]           wstrb,
    output logic                                  bvalid,
    input  logic                                  bready,
    output logic [1:0]                            bresp,
    input  logic                                  arvalid,
    output logic                                  arready,
    input  logic [CSR_ADDR_WIDTH-1:0]             araddr,
    input  logic [2:0]                            arprot,
    output logic                                  rvalid,
    input  logic                                  rready,
    output logic [CSR_DATA_WIDTH-1:0]             rdata,
    output logic [1:0]                            rresp,
    input  logic [((NB_STAT > 0) ? NB_STAT : 1)*CSR_DATA_WIDTH-1:0] csr_i,
    output logic [NB_CTRL*CSR_DATA_WIDTH-1:0]     csr_o,
    output logic [NB_CTRL-1:0]                    csr_wr
);

    localparam int DW       = CSR_DATA_WIDTH;
    localparam int NBYTE    = DW / 8;
    localparam int ADDR_LSB = (DW == 64) ? 3 : 2;
    localparam int IW       = CSR_ADDR_WIDTH - ADDR_LSB;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    logic              aw_held;
    logic              w_held;
    logic [IW-1:0]     aw_idx_q;
    logic [DW-1:0]     w_data_q;
    logic [NBYTE-1:0]  w_strb_q;
    logic [DW-1:0]     ctrl_q [NB_CTRL];

    logic              aw_hs;
    logic              w_hs;
    logic              ar_hs;
    logic              commit;
    logic [31:0]       wr_idx;
    logic [31:0]       rd_idx;
    logic [DW-1:0]     wr_data;
    logic [NBYTE-1:0]  wr_strb;
    logic [NB_CTRL-1:0] wr_sel;
    logic [1:0]        wr_resp;
    logic [DW-1:0]     rd_data_d;
    logic [1:0]        rd_resp_d;
    logic              unused_ok;

    // Ready outputs: single-entry holding per channel, and no new write while a response waits
    assign awready = aresetn & ~aw_held & ~bvalid;
    assign wready  = aresetn & ~w_held & ~bvalid;
    assign arready = aresetn & ~rvalid;

    assign aw_hs  = awvalid & awready;
    assign w_hs   = wvalid & wready;
    assign ar_hs  = arvalid & arready;
    assign commit = (aw_held | aw_hs) & (w_held | w_hs);

    // Held values win over the live bus since they arrived first
    assign wr_idx  = aw_held ? 32'(aw_idx_q) : 32'(awaddr[CSR_ADDR_WIDTH-1:ADDR_LSB]);
    assign wr_data = w_held ? w_data_q : wdata;
    assign wr_strb = w_held ? w_strb_q : wstrb;
    assign rd_idx  = 32'(araddr[CSR_ADDR_WIDTH-1:ADDR_LSB]);

    assign unused_ok = ^{awprot, arprot, awaddr[ADDR_LSB-1:0], araddr[ADDR_LSB-1:0]};

    // Write target decode: control select plus the response code for the region hit
    always_comb begin
        wr_sel  = '0;
        wr_resp = RESP_DECERR;
        for (int k = 0; k < NB_CTRL; k++) begin
            if (wr_idx == 32'(k)) begin
                wr_sel[k] = 1'b1;
                wr_resp   = RESP_OKAY;
            end
        end
        for (int k = 0; k < NB_STAT; k++) begin
            if (wr_idx == 32'(NB_CTRL + k)) begin
                wr_resp = RESP_SLVERR;
            end
        end
    end

    // Read mux: control registers show their pre-commit value, status is sampled live
    always_comb begin
        rd_data_d = '0;
        rd_resp_d = RESP_DECERR;
        for (int k = 0; k < NB_CTRL; k++) begin
            if (rd_idx == 32'(k)) begin
                rd_data_d = ctrl_q[k];
                rd_resp_d = RESP_OKAY;
            end
        end
        for (int k = 0; k < NB_STAT; k++) begin
            if (rd_idx == 32'(NB_CTRL + k)) begin
                rd_data_d = csr_i[k*DW +: DW];
                rd_resp_d = RESP_OKAY;
            end
        end
    end

    // AW/W capture and write response; a commit consumes both holding slots
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            aw_held  <= 1'b0;
            w_held   <= 1'b0;
            aw_idx_q <= '0;
            w_data_q <= '0;
            w_strb_q <= '0;
            bvalid   <= 1'b0;
            bresp    <= RESP_OKAY;
        end else begin
            if (commit) begin
                aw_held <= 1'b0;
                w_held  <= 1'b0;
                bvalid  <= 1'b1;
                bresp   <= wr_resp;
            end else begin
                if (aw_hs) begin
                    aw_held  <= 1'b1;
                    aw_idx_q <= awaddr[CSR_ADDR_WIDTH-1:ADDR_LSB];
                end
                if (w_hs) begin
                    w_held   <= 1'b1;
                    w_data_q <= wdata;
                    w_strb_q <= wstrb;
                end
                if (bvalid && bready) begin
                    bvalid <= 1'b0;
                end
            end
        end
    end

    // Control register update with byte strobes and the one-cycle write pulse
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            csr_wr <= '0;
            for (int k = 0; k < NB_CTRL; k++) begin
                ctrl_q[k] <= CTRL_INIT[k*DW +: DW];
            end
        end else begin
            csr_wr <= '0;
            if (commit) begin
                for (int k = 0; k < NB_CTRL; k++) begin
                    if (wr_sel[k]) begin
                        csr_wr[k] <= 1'b1;
                        for (int b = 0; b < NBYTE; b++) begin
                            if (wr_strb[b]) begin
                                ctrl_q[k][b*8 +: 8] <= wr_data[b*8 +: 8];
                            end
                        end
                    end
                end
            end
        end
    end

    // Read response register, held until the master takes it
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            rvalid <= 1'b0;
            rdata  <= '0;
            rresp  <= RESP_OKAY;
        end else if (ar_hs) begin
            rvalid <= 1'b1;
            rdata  <= rd_data_d;
            rresp  <= rd_resp_d;
        end else if (rvalid && rready) begin
            rvalid <= 1'b0;
        end
    end

    // Flatten the control array onto the output bus
    for (genvar g = 0; g < NB_CTRL; g++) begin : g_csr_o
        assign csr_o[g*DW +: DW] = ctrl_q[g];
    end

endmodule
